// File: rtl/enigma_pkg.sv
// Shared types, constants and helpers for the rotor stepping controller
// and the odometer logic it uses.
package enigma_pkg;

  localparam int LETTER_W = 5;
  localparam int ALPHA    = 26;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } ctrl_state_t;

  // Advance a rotor position by one, wrapping 25 back to 0.
  function automatic logic [LETTER_W-1:0] wrap_inc(input logic [LETTER_W-1:0] pos);
    logic [LETTER_W-1:0] res;
    if (pos >= LETTER_W'(ALPHA - 1)) begin
      res = LETTER_W'(0);
    end else begin
      res = pos + LETTER_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/enigma_step_ctrl_if.sv
// Key handshake between the keyboard/debounce front end (master) and the
// stepping controller (slave).
interface enigma_step_ctrl_if;
  import enigma_pkg::*;

  logic                key_valid;
  logic                key_ready;
  logic [LETTER_W-1:0] key_in;

  modport master (output key_valid, output key_in, input key_ready);
  modport slave  (input key_valid, input key_in, output key_ready);

endinterface

// File: rtl/enigma_odometer.sv
// Next-position logic for the three rotors: rotor1 always steps, rotor2
// steps on the rotor1 notch, and (optionally) rotor2 double-steps and
// carries into rotor3 when it sits on its own notch. Purely combinational
// so the decrypt-side replica can reuse it unchanged.
module enigma_odometer
  import enigma_pkg::*;
#(
  parameter int NOTCH1      = 16,
  parameter int NOTCH2      = 4,
  parameter int DOUBLE_STEP = 1
) (
  input  logic [LETTER_W-1:0] p1,
  input  logic [LETTER_W-1:0] p2,
  input  logic [LETTER_W-1:0] p3,
  output logic [LETTER_W-1:0] n1,
  output logic [LETTER_W-1:0] n2,
  output logic [LETTER_W-1:0] n3
);

  logic notch1_hit_s;
  logic notch2_hit_s;

  // Notch detection and the stepped positions; a simultaneous notch hit on
  // both rotors still steps rotor2 only once.
  always_comb begin
    notch1_hit_s = (p1 == LETTER_W'(NOTCH1));
    notch2_hit_s = (DOUBLE_STEP != 0) && (p2 == LETTER_W'(NOTCH2));
    n1 = wrap_inc(p1);
    if (notch1_hit_s || notch2_hit_s) begin
      n2 = wrap_inc(p2);
    end else begin
      n2 = p2;
    end
    if (notch2_hit_s) begin
      n3 = wrap_inc(p3);
    end else begin
      n3 = p3;
    end
  end

endmodule

// File: rtl/enigma_step_ctrl.sv
// Rotor stepping controller: accepts one letter per handshake, steps the
// rotors, holds letter and positions on the rotor chain for a settle
// window and then captures the chain output as the ciphertext letter.
module enigma_step_ctrl
  import enigma_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NOTCH1        = 16,
  parameter int NOTCH2        = 4,
  parameter int DOUBLE_STEP   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  enigma_step_ctrl_if.slave     key_bus,
  input  logic                  load,
  input  logic [3*LETTER_W-1:0] load_pos,
  output logic [LETTER_W-1:0]   rot1_pos,
  output logic [LETTER_W-1:0]   rot2_pos,
  output logic [LETTER_W-1:0]   rot3_pos,
  output logic [LETTER_W-1:0]   dp_in,
  input  logic [LETTER_W-1:0]   enc_in,
  output logic [LETTER_W-1:0]   letter_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  err
);

  ctrl_state_t         state_r, state_nxt_s;
  logic [3:0]          cnt_r, cnt_nxt_s;
  logic [LETTER_W-1:0] p1_r, p2_r, p3_r;
  logic [LETTER_W-1:0] p1_nxt_s, p2_nxt_s, p3_nxt_s;
  logic [LETTER_W-1:0] odo1_s, odo2_s, odo3_s;
  logic [LETTER_W-1:0] dp_r, dp_nxt_s;
  logic [LETTER_W-1:0] letter_r, letter_nxt_s;
  logic                ov_r, ov_nxt_s;
  logic                err_r, err_nxt_s;
  logic                key_ready_s;
  logic                key_legal_s;
  logic                ld1_bad_s, ld2_bad_s, ld3_bad_s;

  enigma_odometer #(
    .NOTCH1      (NOTCH1),
    .NOTCH2      (NOTCH2),
    .DOUBLE_STEP (DOUBLE_STEP)
  ) u_odometer (
    .p1 (p1_r),
    .p2 (p2_r),
    .p3 (p3_r),
    .n1 (odo1_s),
    .n2 (odo2_s),
    .n3 (odo3_s)
  );

  assign key_legal_s = (key_bus.key_in != LETTER_W'(0)) &&
                       (key_bus.key_in <= LETTER_W'(ALPHA));
  assign ld1_bad_s   = (load_pos[4:0]   >= LETTER_W'(ALPHA));
  assign ld2_bad_s   = (load_pos[9:5]   >= LETTER_W'(ALPHA));
  assign ld3_bad_s   = (load_pos[14:10] >= LETTER_W'(ALPHA));

  // Next-state and next-register decode; every register holds unless its
  // state says otherwise, and the strobes default low.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    p1_nxt_s     = p1_r;
    p2_nxt_s     = p2_r;
    p3_nxt_s     = p3_r;
    dp_nxt_s     = dp_r;
    letter_nxt_s = letter_r;
    ov_nxt_s     = 1'b0;
    err_nxt_s    = 1'b0;
    key_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        key_ready_s = !load;
        if (load) begin
          p1_nxt_s  = ld1_bad_s ? LETTER_W'(0) : load_pos[4:0];
          p2_nxt_s  = ld2_bad_s ? LETTER_W'(0) : load_pos[9:5];
          p3_nxt_s  = ld3_bad_s ? LETTER_W'(0) : load_pos[14:10];
          err_nxt_s = ld1_bad_s || ld2_bad_s || ld3_bad_s;
        end else if (key_bus.key_valid) begin
          if (key_legal_s) begin
            dp_nxt_s    = key_bus.key_in;
            state_nxt_s = STEP;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STEP: begin
        p1_nxt_s    = odo1_s;
        p2_nxt_s    = odo2_s;
        p3_nxt_s    = odo3_s;
        cnt_nxt_s   = 4'd0;
        state_nxt_s = SETTLE;
      end
      SETTLE: begin
        if (cnt_r == 4'(SETTLE_CYCLES - 1)) begin
          state_nxt_s = CAPTURE;
        end else begin
          cnt_nxt_s = cnt_r + 4'd1;
        end
      end
      CAPTURE: begin
        letter_nxt_s = enc_in;
        ov_nxt_s     = 1'b1;
        dp_nxt_s     = LETTER_W'(0);
        state_nxt_s  = IDLE;
      end
      default: begin
        dp_nxt_s    = LETTER_W'(0);
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Positions, settle counter, datapath letter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= 4'd0;
      p1_r     <= LETTER_W'(0);
      p2_r     <= LETTER_W'(0);
      p3_r     <= LETTER_W'(0);
      dp_r     <= LETTER_W'(0);
      letter_r <= LETTER_W'(0);
      ov_r     <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      p1_r     <= p1_nxt_s;
      p2_r     <= p2_nxt_s;
      p3_r     <= p3_nxt_s;
      dp_r     <= dp_nxt_s;
      letter_r <= letter_nxt_s;
      ov_r     <= ov_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  assign key_bus.key_ready = key_ready_s;
  assign busy              = (state_r != IDLE);
  assign rot1_pos          = p1_r;
  assign rot2_pos          = p2_r;
  assign rot3_pos          = p3_r;
  assign dp_in             = dp_r;
  assign letter_out        = letter_r;
  assign out_valid         = ov_r;
  assign err               = err_r;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Self-checking bench for enigma_step_ctrl: a vector table of load/key
// records with expected positions, a letter scoreboard fed at key accept
// and drained on out_valid, and hand-written multi-cycle sequences.
module tb_enigma_step_ctrl;
  import enigma_pkg::*;

  typedef struct {
    int do_load;
    int l1, l2, l3;
    int key;
    int e1, e2, e3;
    int n1, n2, n3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [4:0]  key_in = 5'd0;
  logic        load = 1'b0;
  logic [14:0] load_pos = 15'd0;

  logic [4:0] rot1_pos, rot2_pos, rot3_pos, dp_in, enc_in, letter_out;
  logic       out_valid, busy, err;
  logic [4:0] nd_rot1, nd_rot2, nd_rot3, nd_dp_in, nd_enc_in, nd_letter_out;
  logic       nd_out_valid, nd_busy, nd_err;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [4:0] sb[$];
  logic [4:0] exp_letter;
  vec_t       vecs[9];

  enigma_step_ctrl_if kif();
  enigma_step_ctrl_if nd_kif();

  assign kif.key_valid    = key_valid;
  assign kif.key_in       = key_in;
  assign nd_kif.key_valid = key_valid;
  assign nd_kif.key_in    = key_in;

  // Stand-in for the rotor chain: a simple mix of letter and positions.
  function automatic logic [4:0] stub(input int l, input int a, input int b, input int c);
    int s;
    s = ((l + a + b + c) % 26) + 1;
    return 5'(s);
  endfunction

  assign enc_in    = stub(int'(dp_in), int'(rot1_pos), int'(rot2_pos), int'(rot3_pos));
  assign nd_enc_in = stub(int'(nd_dp_in), int'(nd_rot1), int'(nd_rot2), int'(nd_rot3));

  enigma_step_ctrl #(
    .SETTLE_CYCLES (2), .NOTCH1 (16), .NOTCH2 (4), .DOUBLE_STEP (1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .key_bus (kif),
    .load (load), .load_pos (load_pos),
    .rot1_pos (rot1_pos), .rot2_pos (rot2_pos), .rot3_pos (rot3_pos),
    .dp_in (dp_in), .enc_in (enc_in), .letter_out (letter_out),
    .out_valid (out_valid), .busy (busy), .err (err)
  );

  enigma_step_ctrl #(
    .SETTLE_CYCLES (2), .NOTCH1 (16), .NOTCH2 (4), .DOUBLE_STEP (0)
  ) dut_nd (
    .clk (clk), .rst_n (rst_n), .key_bus (nd_kif),
    .load (load), .load_pos (load_pos),
    .rot1_pos (nd_rot1), .rot2_pos (nd_rot2), .rot3_pos (nd_rot3),
    .dp_in (nd_dp_in), .enc_in (nd_enc_in), .letter_out (nd_letter_out),
    .out_valid (nd_out_valid), .busy (nd_busy), .err (nd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard drain: every out_valid must match the oldest accepted key.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out_valid: got letter %0d expected no output", letter_out);
      end else begin
        exp_letter = sb.pop_front();
        chk("letter_out", int'(letter_out), int'(exp_letter));
      end
    end
  end

  task automatic chk_pos(input string name, input int a, input int b, input int c);
    chk({name, "_rot1"}, int'(rot1_pos), a);
    chk({name, "_rot2"}, int'(rot2_pos), b);
    chk({name, "_rot3"}, int'(rot3_pos), c);
  endtask

  task automatic do_load(input int a, input int b, input int c, input int exp_err);
    load     = 1'b1;
    load_pos = {5'(c), 5'(b), 5'(a)};
    @(posedge clk); #1;
    load = 1'b0;
    chk("load_err", int'(err), exp_err);
    chk_pos("load", (a >= 26) ? 0 : a, (b >= 26) ? 0 : b, (c >= 26) ? 0 : c);
    @(posedge clk); #1;
    chk("load_err_clear", int'(err), 0);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) break;
    end
  endtask

  task automatic run_key(input vec_t v);
    int cyc;
    bit got;
    key_valid = 1'b1;
    key_in    = 5'(v.key);
    sb.push_back(stub(v.key, v.e1, v.e2, v.e3));
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("accept_busy", int'(busy), 1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) begin
        chk("settle_dp_in", int'(dp_in), v.key);
        chk_pos("step", v.e1, v.e2, v.e3);
        chk("nd_rot1", int'(nd_rot1), v.n1);
        chk("nd_rot2", int'(nd_rot2), v.n2);
        chk("nd_rot3", int'(nd_rot3), v.n3);
      end
      if (out_valid) got = 1'b1;
    end
    chk("latency", cyc, 4);
    chk("ready_with_out_valid", int'(kif.key_ready), 1);
    chk("idle_dp_in", int'(dp_in), 0);
  endtask

  initial begin
    int c1, c2;
    vecs[0] = '{0,  0,  0,  0,  1,  1,  0,  0,  1,  0,  0};
    vecs[1] = '{1, 16,  0,  0,  5, 17,  1,  0, 17,  1,  0};
    vecs[2] = '{1, 17,  0,  0,  5, 18,  0,  0, 18,  0,  0};
    vecs[3] = '{1,  5,  4,  0,  7,  6,  5,  1,  6,  4,  0};
    vecs[4] = '{1, 25, 25, 25, 26,  0, 25, 25,  0, 25, 25};
    vecs[5] = '{1, 16, 25, 25, 12, 17,  0, 25, 17,  0, 25};
    vecs[6] = '{1, 16,  4,  2,  3, 17,  5,  3, 17,  5,  2};
    vecs[7] = '{1,  0,  4, 25, 20,  1,  5,  0,  1,  4, 25};
    vecs[8] = '{1, 15,  3,  7, 13, 16,  3,  7, 16,  3,  7};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_pos("reset", 0, 0, 0);
    chk("reset_dp_in", int'(dp_in), 0);
    chk("reset_letter_out", int'(letter_out), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_key_ready", int'(kif.key_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven stepping vectors
    foreach (vecs[i]) begin
      if (vecs[i].do_load != 0) do_load(vecs[i].l1, vecs[i].l2, vecs[i].l3, 0);
      run_key(vecs[i]);
    end

    // Illegal load fields
    do_load(30, 3, 27, 1);
    do_load(26, 25, 0, 1);

    // Illegal keys: consumed with err, no output, positions unchanged
    key_valid = 1'b1;
    key_in    = 5'd0;
    @(posedge clk); #1;
    chk("badkey0_err", int'(err), 1);
    chk("badkey0_busy", int'(busy), 0);
    key_in = 5'd27;
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("badkey27_err", int'(err), 1);
    chk("badkey27_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("badkey_err_clear", int'(err), 0);
    repeat (5) @(posedge clk);
    #1;
    chk_pos("badkey", 0, 25, 0);

    // Load and key in the same cycle: load wins, key taken next cycle
    load      = 1'b1;
    load_pos  = {5'd0, 5'd0, 5'd2};
    key_valid = 1'b1;
    key_in    = 5'd3;
    #1;
    chk("contend_key_ready", int'(kif.key_ready), 0);
    @(posedge clk); #1;
    load = 1'b0;
    chk("contend_busy", int'(busy), 0);
    chk_pos("contend_load", 2, 0, 0);
    sb.push_back(stub(3, 3, 0, 0));
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("contend_accept", int'(busy), 1);
    wait_out(c1);
    chk("contend_latency", c1, 4);
    chk_pos("contend_step", 3, 0, 0);

    // Key held through busy: re-accepted on first IDLE cycle
    key_valid = 1'b1;
    key_in    = 5'd9;
    sb.push_back(stub(9, 4, 0, 0));
    sb.push_back(stub(9, 5, 0, 0));
    @(posedge clk); #1;
    wait_out(c1);
    chk("held_latency", c1, 4);
    chk("held_ready", int'(kif.key_ready), 1);
    wait_out(c2);
    key_valid = 1'b0;
    chk("held_throughput", c2, 5);
    chk_pos("held", 5, 0, 0);

    // Reset during SETTLE aborts the key
    key_valid = 1'b1;
    key_in    = 5'd4;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_settle_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_pos("abort", 0, 0, 0);
    chk("abort_dp_in", int'(dp_in), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_key_ready", int'(kif.key_ready), 1);
    repeat (5) @(posedge clk);
    #1;
    run_key(vecs[0]);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
